// File: rtl/map_mem_arb.sv
// map_mem_arb: arbitrates one host port and CH_NUM toggle-handshake channels onto a single memory strobe.
// Defining MAP_MEM_ARB_PREEMPT_EN lets a host request abort an in-flight channel access.
//   state | meaning
//   IDLE  | no access in flight; grant is evaluated here
//   HOST  | host access strobing memory
//   CH    | channel access strobing memory
module map_mem_arb #(
    parameter int CH_NUM  = 2,
    parameter int AW      = 21,
    parameter int ACC_CYC = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 host_oe,
    input  logic                 host_we,
    input  logic [AW-1:0]        host_addr,
    input  logic [15:0]          host_di,
    output logic [15:0]          host_do,
    input  logic [CH_NUM-1:0]    ch_req,
    output logic [CH_NUM-1:0]    ch_ack,
    input  logic [CH_NUM-1:0]    ch_we,
    input  logic [CH_NUM*AW-1:0] ch_addr,
    input  logic [CH_NUM*16-1:0] ch_di,
    output logic [15:0]          ch_do,
    output logic [AW-1:0]        mem_addr,
    output logic [15:0]          mem_di,
    input  logic [15:0]          mem_do,
    output logic                 mem_oe,
    output logic                 mem_we,
    output logic                 busy
);

    localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOST = 2'd1,
        CH   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [1:0]        oe_sr, we_sr;
    logic              oe_sync, we_sync, host_sync;
    logic              host_pend, host_rd_q;
    logic [AW-1:0]     host_addr_q;
    logic [15:0]       host_di_q, host_buf;
    logic [CW-1:0]     rr_ptr, ch_sel, grant_idx;
    logic [2:0]        cnt;
    logic [CH_NUM-1:0] ch_pend;
    logic              grant_found, acc_done, acc_abort;

    assign oe_sync   = ~oe_sr[1] & oe_sr[0];
    assign we_sync   = ~we_sr[1] & we_sr[0];
    assign host_sync = oe_sync | we_sync;
    assign ch_pend   = ch_req ^ ch_ack;
    assign busy      = (state != IDLE);
    assign host_do   = (state == HOST && mem_oe) ? mem_do : host_buf;

    // Round-robin search starts one past the last completed channel.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= CH_NUM; k++) begin
            if (!grant_found && ch_pend[(int'(rr_ptr) + k) % CH_NUM]) begin
                grant_found = 1'b1;
                grant_idx   = CW'((int'(rr_ptr) + k) % CH_NUM);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        acc_done  = 1'b0;
        acc_abort = 1'b0;
        case (state)
            IDLE: begin
                if (host_pend)
                    state_nxt = HOST;
                else if (grant_found)
                    state_nxt = CH;
            end
            HOST: begin
                if (cnt == 3'd0) begin
                    acc_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            CH: begin
                if (cnt == 3'd0) begin
                    acc_done  = 1'b1;
                    state_nxt = IDLE;
                end
`ifdef MAP_MEM_ARB_PREEMPT_EN
                // cnt != 0 means at least two strobe clocks remain, counting this one.
                else if (host_sync) begin
                    acc_abort = 1'b1;
                    state_nxt = IDLE;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            oe_sr       <= 2'b00;
            we_sr       <= 2'b00;
            host_pend   <= 1'b0;
            host_rd_q   <= 1'b0;
            host_addr_q <= '0;
            host_di_q   <= '0;
            host_buf    <= '0;
            ch_do       <= '0;
            mem_addr    <= '0;
            mem_di      <= '0;
            mem_oe      <= 1'b0;
            mem_we      <= 1'b0;
            cnt         <= '0;
            ch_sel      <= '0;
            rr_ptr      <= CW'(CH_NUM - 1);
            ch_ack      <= ch_req;
        end else begin
            oe_sr <= {oe_sr[0], host_oe};
            we_sr <= {we_sr[0], host_we};

            // A new request wins over the clear so one arriving at grant is not lost.
            if (host_sync) begin
                host_pend   <= 1'b1;
                host_addr_q <= host_addr;
                host_di_q   <= host_di;
                host_rd_q   <= oe_sync;
            end else if (state == IDLE && host_pend) begin
                host_pend <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (host_pend) begin
                        mem_addr <= host_addr_q;
                        mem_di   <= host_di_q;
                        mem_oe   <= host_rd_q;
                        mem_we   <= ~host_rd_q;
                        cnt      <= 3'(ACC_CYC - 1);
                    end else if (grant_found) begin
                        ch_sel   <= grant_idx;
                        mem_addr <= ch_addr[grant_idx*AW +: AW];
                        mem_di   <= ch_di[grant_idx*16 +: 16];
                        mem_oe   <= ~ch_we[grant_idx];
                        mem_we   <= ch_we[grant_idx];
                        cnt      <= 3'(ACC_CYC - 1);
                    end
                end
                HOST, CH: begin
                    if (acc_done) begin
                        mem_oe <= 1'b0;
                        mem_we <= 1'b0;
                        if (state == HOST) begin
                            if (mem_oe)
                                host_buf <= mem_do;
                        end else begin
                            if (mem_oe)
                                ch_do <= mem_do;
                            ch_ack[ch_sel] <= ~ch_ack[ch_sel];
                            rr_ptr         <= ch_sel;
                        end
                    end else if (acc_abort) begin
                        mem_oe <= 1'b0;
                        mem_we <= 1'b0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: begin
                    mem_oe <= 1'b0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_map_mem_arb.sv
// tb_map_mem_arb: directed scenarios for map_mem_arb (CH_NUM=2, AW=21, ACC_CYC=3).
// Expectations follow MAP_MEM_ARB_PREEMPT_EN when the bench is built with it.
module tb_map_mem_arb;
    localparam int AW = 21;
    localparam int CH = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            host_oe, host_we;
    logic [AW-1:0]   host_addr;
    logic [15:0]     host_di;
    logic [15:0]     host_do;
    logic [CH-1:0]   ch_req, ch_ack, ch_we;
    logic [CH*AW-1:0] ch_addr;
    logic [CH*16-1:0] ch_di;
    logic [15:0]     ch_do;
    logic [AW-1:0]   mem_addr;
    logic [15:0]     mem_di, mem_do;
    logic            mem_oe, mem_we, busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Memory model: a fixed word at 0x00100, address-derived data elsewhere.
    assign mem_do = (mem_addr == 21'h00100) ? 16'hBEEF : (mem_addr[15:0] ^ 16'hC3C3);

    map_mem_arb #(.CH_NUM(CH), .AW(AW), .ACC_CYC(3)) dut (
        .clk(clk), .rst(rst),
        .host_oe(host_oe), .host_we(host_we), .host_addr(host_addr),
        .host_di(host_di), .host_do(host_do),
        .ch_req(ch_req), .ch_ack(ch_ack), .ch_we(ch_we),
        .ch_addr(ch_addr), .ch_di(ch_di), .ch_do(ch_do),
        .mem_addr(mem_addr), .mem_di(mem_di), .mem_do(mem_do),
        .mem_oe(mem_oe), .mem_we(mem_we), .busy(busy)
    );

    // Access recorder: one entry per contiguous strobe episode.
    logic          rec_en = 1'b0;
    int            ep_n;
    logic [AW-1:0] ep_addr [4];
    int            ep_len  [4];
    logic          ep_wr   [4];
    logic [15:0]   ep_di   [4];
    int            ep_gap  [4];
    int            idle_run;
    logic          prev_act;
    int            ack_tog [CH];
    logic [CH-1:0] prev_ack;

    always @(negedge clk) begin
        if (rec_en) begin
            if ((mem_oe || mem_we) && !prev_act) begin
                if (ep_n < 4) begin
                    ep_addr[ep_n] = mem_addr;
                    ep_len[ep_n]  = 1;
                    ep_wr[ep_n]   = mem_we;
                    ep_di[ep_n]   = mem_di;
                    ep_gap[ep_n]  = idle_run;
                end
                ep_n++;
            end else if ((mem_oe || mem_we) && ep_n >= 1 && ep_n <= 4) begin
                ep_len[ep_n-1]++;
            end
            idle_run = busy ? 0 : idle_run + 1;
            for (int c = 0; c < CH; c++)
                if (ch_ack[c] !== prev_ack[c]) ack_tog[c]++;
            prev_ack = ch_ack;
            prev_act = mem_oe || mem_we;
        end
    end

    task automatic rec_start();
        ep_n     = 0;
        idle_run = 0;
        prev_act = 1'b0;
        prev_ack = ch_ack;
        for (int i = 0; i < 4; i++) begin
            ep_addr[i] = '0; ep_len[i] = 0; ep_wr[i] = 1'b0; ep_di[i] = '0; ep_gap[i] = 0;
        end
        for (int c = 0; c < CH; c++) ack_tog[c] = 0;
        rec_en = 1'b1;
    endtask

    task automatic test_reset();
        int act;
        rst = 1'b1; host_oe = 1'b0; host_we = 1'b0; host_addr = '0; host_di = '0;
        ch_req = 2'b10; ch_we = 2'b00; ch_addr = '0; ch_di = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (mem_oe !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_strobes: got oe=%b we=%b want 0/0", mem_oe, mem_we); end
        checks++; if (mem_addr !== 21'h0 || mem_di !== 16'h0) begin errors++; $display("FAIL reset_mem_bus: got addr=%h di=%h want 0/0", mem_addr, mem_di); end
        checks++; if (host_do !== 16'h0 || ch_do !== 16'h0) begin errors++; $display("FAIL reset_data: got host_do=%h ch_do=%h want 0/0", host_do, ch_do); end
        checks++; if (ch_ack !== 2'b10) begin errors++; $display("FAIL reset_ack: got %b want 10", ch_ack); end
        act = 0;
        repeat (6) begin @(negedge clk); if (mem_oe || mem_we || busy) act++; end
        checks++; if (act !== 0) begin errors++; $display("FAIL reset_quiet: got %0d active cycles want 0", act); end
    endtask

    task automatic test_host_read();
        int bad_do = 0;
        @(posedge clk); #1;
        rec_start();
        host_addr = 21'h00100; host_oe = 1'b1;
        repeat (15) begin @(negedge clk); if (mem_oe && host_do !== 16'hBEEF) bad_do++; end
        host_oe = 1'b0;
        checks++; if (ep_n !== 1) begin errors++; $display("FAIL hrd_count: got %0d accesses want 1", ep_n); end
        checks++; if (ep_addr[0] !== 21'h00100 || ep_wr[0] !== 1'b0) begin errors++; $display("FAIL hrd_addr: got addr=%h wr=%b want 00100/0", ep_addr[0], ep_wr[0]); end
        checks++; if (ep_len[0] !== 3) begin errors++; $display("FAIL hrd_len: got %0d want 3", ep_len[0]); end
        checks++; if (bad_do !== 0) begin errors++; $display("FAIL hrd_passthru: got %0d bad cycles want 0", bad_do); end
        checks++; if (host_do !== 16'hBEEF || busy !== 1'b0) begin errors++; $display("FAIL hrd_after: got host_do=%h busy=%b want BEEF/0", host_do, busy); end
    endtask

    task automatic test_host_write();
        int bad_do = 0;
        @(posedge clk); #1;
        rec_start();
        host_addr = 21'h00200; host_di = 16'hCAFE; host_we = 1'b1;
        repeat (15) begin @(negedge clk); if (host_do !== 16'hBEEF) bad_do++; end
        host_we = 1'b0;
        checks++; if (ep_n !== 1) begin errors++; $display("FAIL hwr_count: got %0d accesses want 1", ep_n); end
        checks++; if (ep_addr[0] !== 21'h00200 || ep_wr[0] !== 1'b1 || ep_di[0] !== 16'hCAFE) begin errors++; $display("FAIL hwr_bus: got addr=%h wr=%b di=%h want 00200/1/CAFE", ep_addr[0], ep_wr[0], ep_di[0]); end
        checks++; if (ep_len[0] !== 3) begin errors++; $display("FAIL hwr_len: got %0d want 3", ep_len[0]); end
        checks++; if (bad_do !== 0) begin errors++; $display("FAIL hwr_buf_kept: got %0d cycles with host_do != BEEF want 0", bad_do); end
    endtask

    task automatic test_ch_pair();
        @(posedge clk); #1;
        ch_addr = {21'h00080, 21'h00040}; ch_we = 2'b00;
        rec_start();
        ch_req = ch_req ^ 2'b11;
        repeat (25) @(negedge clk);
        checks++; if (ep_n !== 2) begin errors++; $display("FAIL pair_count: got %0d accesses want 2", ep_n); end
        checks++; if (ep_addr[0] !== 21'h00040 || ep_addr[1] !== 21'h00080) begin errors++; $display("FAIL pair_order: got %h,%h want 00040,00080", ep_addr[0], ep_addr[1]); end
        checks++; if (ep_len[0] !== 3 || ep_len[1] !== 3) begin errors++; $display("FAIL pair_len: got %0d,%0d want 3,3", ep_len[0], ep_len[1]); end
        checks++; if (ep_gap[1] !== 1) begin errors++; $display("FAIL pair_gap: got %0d idle clocks want 1", ep_gap[1]); end
        checks++; if (ack_tog[0] !== 1 || ack_tog[1] !== 1) begin errors++; $display("FAIL pair_acks: got %0d,%0d toggles want 1,1", ack_tog[0], ack_tog[1]); end
        checks++; if (ch_ack !== 2'b01) begin errors++; $display("FAIL pair_ack_val: got %b want 01", ch_ack); end
        checks++; if (ch_do !== 16'hC343) begin errors++; $display("FAIL pair_ch_do: got %h want C343", ch_do); end
    endtask

    task automatic test_ch_write();
        @(posedge clk); #1;
        ch_addr[2*AW-1:AW] = 21'h10020; ch_di[31:16] = 16'h1234; ch_we = 2'b10;
        rec_start();
        ch_req[1] = ~ch_req[1];
        repeat (20) @(negedge clk);
        checks++; if (ep_n !== 1) begin errors++; $display("FAIL cwr_count: got %0d accesses want 1", ep_n); end
        checks++; if (ep_addr[0] !== 21'h10020 || ep_wr[0] !== 1'b1 || ep_di[0] !== 16'h1234) begin errors++; $display("FAIL cwr_bus: got addr=%h wr=%b di=%h want 10020/1/1234", ep_addr[0], ep_wr[0], ep_di[0]); end
        checks++; if (ep_len[0] !== 3) begin errors++; $display("FAIL cwr_len: got %0d want 3", ep_len[0]); end
        checks++; if (ack_tog[1] !== 1 || ack_tog[0] !== 0) begin errors++; $display("FAIL cwr_acks: got ch0=%0d ch1=%0d toggles want 0,1", ack_tog[0], ack_tog[1]); end
        checks++; if (ch_do !== 16'hC343 || host_do !== 16'hBEEF) begin errors++; $display("FAIL cwr_data_kept: got ch_do=%h host_do=%h want C343/BEEF", ch_do, host_do); end
    endtask

    task automatic test_preempt();
        int waited = 0;
        int exp_n;
        logic [AW-1:0] exp_addr [3];
        int exp_len [3];
`ifdef MAP_MEM_ARB_PREEMPT_EN
        exp_n = 3;
        exp_addr[0] = 21'h00300; exp_len[0] = 2;
        exp_addr[1] = 21'h00100; exp_len[1] = 3;
        exp_addr[2] = 21'h00300; exp_len[2] = 3;
`else
        exp_n = 2;
        exp_addr[0] = 21'h00300; exp_len[0] = 3;
        exp_addr[1] = 21'h00100; exp_len[1] = 3;
        exp_addr[2] = 21'h00000; exp_len[2] = 0;
`endif
        @(posedge clk); #1;
        ch_addr[AW-1:0] = 21'h00300; ch_we = 2'b00;
        rec_start();
        ch_req[0] = ~ch_req[0];
        do begin @(negedge clk); waited++; end while (!mem_oe && waited < 10);
        checks++; if (mem_oe !== 1'b1) begin errors++; $display("FAIL pre_start: got mem_oe=%b after %0d clocks want 1", mem_oe, waited); end
        host_addr = 21'h00100; host_oe = 1'b1;
        repeat (25) @(negedge clk);
        host_oe = 1'b0;
        checks++; if (ep_n !== exp_n) begin errors++; $display("FAIL pre_count: got %0d accesses want %0d", ep_n, exp_n); end
        for (int i = 0; i < exp_n; i++) begin
            checks++;
            if (ep_addr[i] !== exp_addr[i] || ep_len[i] !== exp_len[i]) begin
                errors++; $display("FAIL pre_access%0d: got addr=%h len=%0d want %h/%0d", i, ep_addr[i], ep_len[i], exp_addr[i], exp_len[i]);
            end
        end
        checks++; if (ep_gap[1] !== 1) begin errors++; $display("FAIL pre_gap: got %0d idle clocks want 1", ep_gap[1]); end
        checks++; if (ack_tog[0] !== 1 || ack_tog[1] !== 0) begin errors++; $display("FAIL pre_acks: got ch0=%0d ch1=%0d toggles want 1,0", ack_tog[0], ack_tog[1]); end
        checks++; if (ch_do !== 16'hC0C3 || host_do !== 16'hBEEF) begin errors++; $display("FAIL pre_data: got ch_do=%h host_do=%h want C0C3/BEEF", ch_do, host_do); end
    endtask

    task automatic test_reset_mid();
        int waited = 0;
        @(posedge clk); #1;
        ch_addr[AW-1:0] = 21'h00400; ch_we = 2'b00;
        ch_req[0] = ~ch_req[0];
        do begin @(negedge clk); waited++; end while (!mem_oe && waited < 10);
        @(negedge clk);
        checks++; if (mem_oe !== 1'b1) begin errors++; $display("FAIL rmid_strobe2: got mem_oe=%b want 1", mem_oe); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (mem_oe !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_drop: got oe=%b busy=%b want 0/0", mem_oe, busy); end
        checks++; if (ch_ack !== ch_req) begin errors++; $display("FAIL rmid_ack: got %b want %b", ch_ack, ch_req); end
        checks++; if (ch_do !== 16'h0 || host_do !== 16'h0) begin errors++; $display("FAIL rmid_data: got ch_do=%h host_do=%h want 0/0", ch_do, host_do); end
        rst = 1'b0;
        rec_start();
        repeat (10) @(negedge clk);
        checks++; if (ep_n !== 0 || ack_tog[0] !== 0 || ack_tog[1] !== 0) begin errors++; $display("FAIL rmid_quiet: got %0d accesses, toggles %0d,%0d want 0,0,0", ep_n, ack_tog[0], ack_tog[1]); end
    endtask

    initial begin
        test_reset();
        test_host_read();
        test_host_write();
        test_ch_pair();
        test_ch_write();
        test_preempt();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end
endmodule
